gps_accum_reader: RTL and testbench

Wishbone master that drains the GPS correlator register file after each accumulation interrupt. It is the initiator for the correlator's Wishbone slave.
- On a rising edge of accum_int it reads STATUS, NEW_DATA and, when channel 0 has new data, the ten channel-0 measurement registers.
- Each burst becomes one record that is pushed into an internal FIFO and streamed out via valid/ready, so firmware or DMA no longer polls per word.

---
 rtl/gps_accum_reader_pkg.sv | 25 ++
 rtl/gps_accum_reader_if.sv | 29 ++
 rtl/gps_accum_fifo.sv | 60 ++++++
 rtl/gps_accum_reader.sv | 179 +++++++++++++++++
 tb/tb_gps_accum_reader.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gps_accum_reader_pkg.sv
// Shared constants, FSM state type and byte-order helper for the correlator reader.
// Offsets are Wishbone word offsets into the correlator register file.
package gps_accum_pkg;

    localparam logic [7:0]  OFS_STATUS    = 8'hE0;
    localparam logic [7:0]  OFS_NEWDATA   = 8'hE1;
    localparam logic [7:0]  OFS_CH0_FIRST = 8'h04;
    localparam logic [7:0]  OFS_CH0_LAST  = 8'h0D;
    localparam logic [15:0] HDR_TAG       = 16'hACC0;
    localparam int          REC_MAX       = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RD_STATUS,
        ST_RD_NEWDATA,
        ST_RD_CH0
    } state_e;

    // The slave presents registers byte-swapped; restore natural order.
    function automatic logic [31:0] unswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/gps_accum_reader_if.sv
// Wishbone read-master signals plus the record stream (valid/ready, last flag).
// master = reader side, slave = correlator model / stream consumer side.
interface gps_accum_reader_if;

    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic        wbm_ack_i;
    logic [31:0] rec_data;
    logic        rec_valid;
    logic        rec_ready;
    logic        rec_last;

    modport master (
        output wbm_adr_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output rec_data, rec_valid, rec_last,
        input  wbm_dat_i, wbm_ack_i, rec_ready
    );

    modport slave (
        input  wbm_adr_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  rec_data, rec_valid, rec_last,
        output wbm_dat_i, wbm_ack_i, rec_ready
    );

endinterface

// File: rtl/gps_accum_fifo.sv
// First-word-fall-through FIFO; only committed words are visible to the reader.
// Writes past the commit point can be rewound; push is never blocked (caller checks free_o).
module gps_accum_fifo #(
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 33
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_dat_i,
    input  logic                  commit_i,
    input  logic                  rewind_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      pop_dat_o,
    output logic                  pop_vld_o,
    output logic [DEPTH_LOG2:0]   free_o
);

    localparam int                  DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE     = (DEPTH_LOG2 + 1)'(1);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_q, rd_q, cmt_q;
    logic [DEPTH_LOG2:0] wr_inc;

    assign wr_inc = wr_q + ONE;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q[DEPTH_LOG2-1:0]] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cmt_q <= '0;
        end else begin
            if (rewind_i) begin
                wr_q <= cmt_q;
            end else if (push_i) begin
                wr_q <= wr_inc;
            end
            // Commit may coincide with the record's final push.
            if (commit_i) begin
                cmt_q <= push_i ? wr_inc : wr_q;
            end
            if (pop_i && pop_vld_o) begin
                rd_q <= rd_q + ONE;
            end
        end
    end

    assign pop_vld_o = (rd_q != cmt_q);
    assign pop_dat_o = mem_q[rd_q[DEPTH_LOG2-1:0]];
    assign free_o    = DEPTH_W - (wr_q - rd_q);

endmodule

// File: rtl/gps_accum_reader.sv
// Drains the correlator register file on each accum_int rising edge into 1- or 11-word records.
// Single Wishbone reads with one idle cycle between them; records stream out via valid/ready.
module gps_accum_reader
    import gps_accum_pkg::*;
#(
    parameter logic [31:0] BASE_ADR        = 32'h0000_0000,
    parameter int          FIFO_DEPTH_LOG2 = 5,
    parameter int          TIMEOUT         = 16
) (
    input  logic                      correlator_clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic                      accum_int,
    gps_accum_reader_if.master        bus,
    output logic [7:0]                overrun_cnt,
    output logic                      timeout_err,
    output logic                      busy
);

    localparam int                       TMO_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0]         TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] NEED     = (FIFO_DEPTH_LOG2 + 1)'(REC_MAX + 1);

    state_e                 state_q, state_d;
    logic [7:0]             ofs_q, ofs_d;
    logic                   cyc_q, cyc_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [1:0]             status_q, status_d;
    logic                   drop_q, drop_d;
    logic [7:0]             ovr_q, ovr_d;
    logic                   terr_q, terr_d;
    logic                   acc_dly_q, trig_q;

    logic                   push, commit, rewind;
    logic [32:0]            push_dat;
    logic [32:0]            pop_dat;
    logic                   pop_vld;
    logic [FIFO_DEPTH_LOG2:0] free;
    logic [31:0]            rd_word;

    assign rd_word = unswap(bus.wbm_dat_i);

    always_ff @(posedge correlator_clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            ofs_q     <= '0;
            cyc_q     <= 1'b0;
            tmo_q     <= '0;
            status_q  <= '0;
            drop_q    <= 1'b0;
            ovr_q     <= '0;
            terr_q    <= 1'b0;
            acc_dly_q <= 1'b0;
            trig_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ofs_q     <= ofs_d;
            cyc_q     <= cyc_d;
            tmo_q     <= tmo_d;
            status_q  <= status_d;
            drop_q    <= drop_d;
            ovr_q     <= ovr_d;
            terr_q    <= terr_d;
            acc_dly_q <= accum_int;
            trig_q    <= accum_int & ~acc_dly_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        ofs_d    = ofs_q;
        cyc_d    = cyc_q;
        tmo_d    = tmo_q;
        status_d = status_q;
        drop_d   = drop_q;
        ovr_d    = ovr_q;
        terr_d   = terr_q;
        push     = 1'b0;
        push_dat = '0;
        commit   = 1'b0;
        rewind   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trig_q && enable) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Without room for a worst-case record we still read STATUS to clear the interrupt.
                drop_d = (free < NEED);
                if ((free < NEED) && (ovr_q != 8'hFF)) begin
                    ovr_d = ovr_q + 8'd1;
                end
                ofs_d   = OFS_STATUS;
                cyc_d   = 1'b1;
                tmo_d   = '0;
                state_d = ST_RD_STATUS;
            end
            default: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    tmo_d = '0;
                end else if (bus.wbm_ack_i) begin
                    cyc_d = 1'b0;
                    case (state_q)
                        ST_RD_STATUS: begin
                            status_d = rd_word[1:0];
                            if (drop_q) begin
                                state_d = ST_IDLE;
                            end else begin
                                ofs_d   = OFS_NEWDATA;
                                state_d = ST_RD_NEWDATA;
                            end
                        end
                        ST_RD_NEWDATA: begin
                            push     = 1'b1;
                            push_dat = {~rd_word[0], HDR_TAG, 2'b00, rd_word[11:0], status_q};
                            if (!rd_word[0]) begin
                                commit  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                ofs_d   = OFS_CH0_FIRST;
                                state_d = ST_RD_CH0;
                            end
                        end
                        default: begin
                            push     = 1'b1;
                            push_dat = {(ofs_q == OFS_CH0_LAST), rd_word};
                            if (ofs_q == OFS_CH0_LAST) begin
                                commit  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                ofs_d = ofs_q + 8'd1;
                            end
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    terr_d  = 1'b1;
                    rewind  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    gps_accum_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (33)
    ) u_fifo (
        .clk_i      (correlator_clk),
        .rstn_i     (rstn),
        .push_i     (push),
        .push_dat_i (push_dat),
        .commit_i   (commit),
        .rewind_i   (rewind),
        .pop_i      (bus.rec_ready),
        .pop_dat_o  (pop_dat),
        .pop_vld_o  (pop_vld),
        .free_o     (free)
    );

    assign bus.wbm_adr_o = cyc_q ? (BASE_ADR + {22'd0, ofs_q, 2'b00}) : 32'd0;
    assign bus.wbm_sel_o = 4'hF;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = 1'b0;
    assign bus.rec_valid = pop_vld;
    assign bus.rec_data  = pop_vld ? pop_dat[31:0] : 32'd0;
    assign bus.rec_last  = pop_vld & pop_dat[32];

    assign overrun_cnt = ovr_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gps_accum_reader.sv
// Randomized bench: Wishbone slave model plus a record-level reference model of the reader.
module tb_gps_accum_reader;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       enable = 1'b0;
    logic       accum_int = 1'b0;
    logic [7:0] overrun_cnt;
    logic       timeout_err;
    logic       busy;

    gps_accum_reader_if bus ();

    gps_accum_reader #(
        .BASE_ADR        (BASE),
        .FIFO_DEPTH_LOG2 (4),
        .TIMEOUT         (16)
    ) dut (
        .correlator_clk (clk),
        .rstn           (rstn),
        .enable         (enable),
        .accum_int      (accum_int),
        .bus            (bus),
        .overrun_cnt    (overrun_cnt),
        .timeout_err    (timeout_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- correlator slave model ----------------
    logic [31:0] regs [256];
    int          lat = 3;
    int          hold_ofs = -1;
    bit          auto_clear = 1'b1;
    int          set_req = 0, set_seen = 0, clr_req = 0, clr_seen = 0;
    int          cyc_len = 0, last_cyc_len = 0;
    int          n_status_rd = 0;
    logic [31:0] adr_log [$];

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    always @(negedge clk) begin
        logic [7:0] o;
        if (set_req != set_seen) begin
            set_seen  = set_req;
            accum_int = 1'b1;
        end
        if (clr_req != clr_seen) begin
            clr_seen  = clr_req;
            accum_int = 1'b0;
        end
        if (!rstn || !bus.wbm_cyc_o) begin
            if (cyc_len != 0) last_cyc_len = cyc_len;
            bus.wbm_ack_i = 1'b0;
            cyc_len       = 0;
        end else if (!bus.wbm_ack_i) begin
            cyc_len++;
            o = 8'((bus.wbm_adr_o - BASE) >> 2);
            if (cyc_len == 1) begin
                adr_log.push_back(bus.wbm_adr_o);
                check_val("bus_attr", {bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}, {1'b1, 1'b0, 4'hF});
            end
            if (cyc_len == lat && int'(o) != hold_ofs) begin
                bus.wbm_ack_i = 1'b1;
                bus.wbm_dat_i = swap32(regs[o]);
                if (o == 8'hE0) begin
                    n_status_rd++;
                    if (auto_clear) accum_int = 1'b0;
                end
            end
        end
    end

    // ---------------- stream consumer ----------------
    bit          drain_en = 1'b0;
    int          rdy_pct = 100;
    logic [32:0] got_q [$];

    always @(negedge clk) begin
        logic r;
        r = drain_en && ($urandom_range(99) < rdy_pct);
        bus.rec_ready = r;
        if (r && bus.rec_valid && rstn) got_q.push_back({bus.rec_last, bus.rec_data});
    end

    // ---------------- reference model ----------------
    logic [32:0] exp_q [$];
    logic [7:0]  exp_ofs [$];

    task automatic model_record();
        logic [31:0] hdr;
        logic [31:0] nd;
        nd  = regs[8'hE1];
        hdr = {16'hACC0, 2'b00, nd[11:0], regs[8'hE0][1:0]};
        exp_q.push_back({~nd[0], hdr});
        if (nd[0]) begin
            for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), regs[4 + i]});
        end
    endtask

    task automatic model_adrs(input bit dropped);
        exp_ofs.push_back(8'hE0);
        if (!dropped) begin
            exp_ofs.push_back(8'hE1);
            if (regs[8'hE1][0]) begin
                for (int i = 0; i < 10; i++) exp_ofs.push_back(8'(4 + i));
            end
        end
    endtask

    task automatic adr_compare(input string tag);
        check_val($sformatf("%s_nacc", tag), adr_log.size(), exp_ofs.size());
        for (int i = 0; i < exp_ofs.size() && i < adr_log.size(); i++)
            check_val($sformatf("%s_adr%0d", tag, i), adr_log[i], BASE + (32'(exp_ofs[i]) << 2));
        adr_log.delete();
        exp_ofs.delete();
    endtask

    task automatic fire_and_wait(input string tag);
        int c;
        set_req++;
        c = 0;
        while (!busy && c < 50) begin @(negedge clk); c++; end
        check_val({tag, "_busy_rise"}, busy, 1);
        c = 0;
        while (busy && c < 1000) begin @(negedge clk); c++; end
        check_val({tag, "_busy_fall"}, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain_check(input string tag);
        int c;
        c = 0;
        drain_en = 1'b1;
        while (got_q.size() < exp_q.size() && c < 3000) begin @(negedge clk); c++; end
        rdy_pct = 100;
        repeat (6) @(negedge clk);
        drain_en = 1'b0;
        check_val({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_val($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        check_val({tag, "_empty"}, bus.rec_valid, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st0, c;
        for (int i = 0; i < 256; i++) regs[i] = $urandom;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_cyc", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
        check_val("rst_adr", bus.wbm_adr_o, 0);
        check_val("rst_rec", {bus.rec_valid, bus.rec_last, bus.rec_data}, 0);
        check_val("rst_stat", {overrun_cnt, timeout_err, busy}, 0);
        rstn = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // 1: full record, channel regs hold their own offsets
        regs[8'hE0] = 32'h2;
        regs[8'hE1] = 32'h1;
        for (int i = 4; i <= 13; i++) regs[i] = 32'(i);
        model_record(); model_adrs(0);
        fire_and_wait("t1");
        check_val("t1_lat", last_cyc_len, 3);
        adr_compare("t1");
        check_val("t1_hdr_const", exp_q[0], 33'h0_ACC0_0006);
        drain_check("t1");

        // 2: no new data -> header only
        regs[8'hE1] = 32'h0;
        model_record(); model_adrs(0);
        fire_and_wait("t2");
        adr_compare("t2");
        check_val("t2_hdr_const", exp_q[0], 33'h1_ACC0_0002);
        drain_check("t2");

        // enable low: interrupt ignored
        enable = 1'b0;
        st0 = n_status_rd;
        set_req++;
        repeat (30) @(negedge clk);
        check_val("dis_reads", n_status_rd - st0, 0);
        check_val("dis_busy", busy, 0);
        clr_req++;
        repeat (3) @(negedge clk);
        enable = 1'b1;

        // 3: consumer stalled across three interrupts
        regs[8'hE0] = $urandom;
        regs[8'hE1] = $urandom | 32'h1;
        for (int i = 4; i <= 13; i++) regs[i] = $urandom;
        model_record(); model_adrs(0);
        fire_and_wait("t3a");
        regs[8'hE1] = 32'h1;
        model_adrs(1);
        fire_and_wait("t3b");
        model_adrs(1);
        fire_and_wait("t3c");
        adr_compare("t3");
        check_val("t3_overrun", overrun_cnt, 2);
        check_val("t3_valid", bus.rec_valid, 1);
        drain_check("t3");

        // 4: ack withheld at offset 0x07
        hold_ofs = 7;
        regs[8'hE1] = 32'h1;
        model_adrs(0);
        fire_and_wait("t4a");
        check_val("t4_tmo_len", last_cyc_len, 16);
        check_val("t4_terr", timeout_err, 1);
        check_val("t4_nopart", bus.rec_valid, 0);
        check_val("t4_nacc", adr_log.size(), 6);
        adr_log.delete(); exp_ofs.delete();
        hold_ofs = -1;
        model_record(); model_adrs(0);
        fire_and_wait("t4b");
        adr_compare("t4b");
        check_val("t4_terr_sticky", timeout_err, 1);
        drain_check("t4b");

        // 5: reset during the fifth read
        set_req++;
        c = 0;
        while (adr_log.size() < 5 && c < 500) begin @(negedge clk); c++; end
        check_val("t5_reach5", adr_log.size(), 5);
        rstn = 1'b0;
        @(posedge clk); #1;
        check_val("t5_cyc_drop", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_val("t5_empty", bus.rec_valid, 0);
        check_val("t5_ovr", overrun_cnt, 0);
        check_val("t5_terr", timeout_err, 0);
        check_val("t5_busy", busy, 0);
        adr_log.delete();

        // 6: interrupt level held high, then re-pulsed
        auto_clear = 1'b0;
        regs[8'hE1] = 32'h0;
        st0 = n_status_rd;
        model_record();
        fire_and_wait("t6a");
        repeat (50) @(negedge clk);
        check_val("t6_one", n_status_rd - st0, 1);
        check_val("t6_idle", busy, 0);
        clr_req++;
        repeat (3) @(negedge clk);
        auto_clear = 1'b1;
        model_record();
        fire_and_wait("t6b");
        check_val("t6_two", n_status_rd - st0, 2);
        adr_log.delete();
        drain_check("t6");

        // randomized records
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 256; i++) regs[i] = $urandom;
            lat = $urandom_range(1, 6);
            rdy_pct = $urandom_range(20, 100);
            model_record(); model_adrs(0);
            fire_and_wait($sformatf("r%0d", k));
            check_val($sformatf("r%0d_lat", k), last_cyc_len, lat);
            adr_compare($sformatf("r%0d", k));
            drain_check($sformatf("r%0d", k));
        end
        check_val("end_terr", timeout_err, 0);
        check_val("end_ovr", overrun_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
